// File: rtl/hazard_scheduler_pkg.sv
// Shared types for the pipeline hazard scheduler: register addresses, operand
// source selects and scheduler states.
package hazard_scheduler_pkg;

  typedef logic [4:0] creg_addr_t;

  typedef enum logic [3:0] {
    RD      = 4'd0,
    ALUOUTE = 4'd1,
    ALUOUTM = 4'd2,
    MEMDATA = 4'd3,
    WDATA   = 4'd4
  } src_t;

  typedef enum logic [1:0] {
    HZ_RUN         = 2'd0,
    HZ_MDU_WAIT    = 2'd1,
    HZ_FETCH_DRAIN = 2'd2
  } hazard_state_t;

  // x0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input creg_addr_t r, input logic use_r,
                                     input logic regwrite, input creg_addr_t dst);
    return (r != 5'd0) && use_r && regwrite && (dst == r);
  endfunction

endpackage

// File: rtl/hazard_scheduler_fwd_sel.sv
// Per-operand forwarding select and stall request.
// HAZ_FORWARD_EN selects bypassing; otherwise every in-flight producer stalls decode.
module hazard_fwd_sel
  import hazard_scheduler_pkg::*;
(
  input  logic [4:0] ra_i,
  input  logic       use_i,
  input  logic [4:0] e_dst_i,
  input  logic [4:0] m_dst_i,
  input  logic [4:0] w_dst_i,
  input  logic       e_regwrite_i,
  input  logic       m_regwrite_i,
  input  logic       w_regwrite_i,
  input  logic       e_memread_i,
  input  logic       m_memread_i,
  output src_t       src_o,
  output logic       stall_req_o
);

  logic e_hit;
  logic m_hit;
  logic w_hit;

  assign e_hit = reg_match(ra_i, use_i, e_regwrite_i, e_dst_i);
  assign m_hit = reg_match(ra_i, use_i, m_regwrite_i, m_dst_i);
  assign w_hit = reg_match(ra_i, use_i, w_regwrite_i, w_dst_i);

`ifdef HAZ_FORWARD_EN
  // Youngest producer wins; a load in E has no data yet and only stalls.
  always_comb begin
    src_o = RD;
    if (e_hit && !e_memread_i) begin
      src_o = ALUOUTE;
    end else if (m_hit) begin
      src_o = m_memread_i ? MEMDATA : ALUOUTM;
    end else if (w_hit) begin
      src_o = WDATA;
    end
  end

  assign stall_req_o = e_hit && e_memread_i;
`else
  logic unused_memread;

  assign src_o           = RD;
  assign stall_req_o     = e_hit | m_hit | w_hit;
  assign unused_memread  = e_memread_i ^ m_memread_i;
`endif

endmodule

// File: rtl/hazard_scheduler.sv
// Stall/flush/forward scheduler for the 5-stage pipeline.
// Optional feature macro: HAZ_FORWARD_EN (operand forwarding, load-use stalls only).
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_ra1,
  input  logic [4:0]       d_ra2,
  input  logic             d_use1,
  input  logic             d_use2,
  input  logic             e_valid,
  input  logic [4:0]       e_dst,
  input  logic [4:0]       m_dst,
  input  logic [4:0]       w_dst,
  input  logic             e_regwrite,
  input  logic             m_regwrite,
  input  logic             w_regwrite,
  input  logic             e_memread,
  input  logic             m_memread,
  input  logic             e_multi,
  input  logic             e_redirect,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             en_m,
  output logic             en_w,
  output logic             flush_d,
  output logic             bub_e,
  output logic             bub_m,
  output logic [3:0]       fwd_a,
  output logic [3:0]       fwd_b,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT - 1) : 1;
  localparam logic [CW-1:0] MDU_START = CW'((MDU_LAT > 1) ? MDU_LAT - 2 : 0);
  localparam bit MDU_MULTI = (MDU_LAT > 1);

  hazard_state_t    state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  src_t src_a, src_b;
  logic stall_a, stall_b;
  logic data_stall;
  logic mdu_start;

  hazard_fwd_sel u_fwd_a (
    .ra_i         (d_ra1),
    .use_i        (d_use1),
    .e_dst_i      (e_dst),
    .m_dst_i      (m_dst),
    .w_dst_i      (w_dst),
    .e_regwrite_i (e_regwrite),
    .m_regwrite_i (m_regwrite),
    .w_regwrite_i (w_regwrite),
    .e_memread_i  (e_memread),
    .m_memread_i  (m_memread),
    .src_o        (src_a),
    .stall_req_o  (stall_a)
  );

  hazard_fwd_sel u_fwd_b (
    .ra_i         (d_ra2),
    .use_i        (d_use2),
    .e_dst_i      (e_dst),
    .m_dst_i      (m_dst),
    .w_dst_i      (w_dst),
    .e_regwrite_i (e_regwrite),
    .m_regwrite_i (m_regwrite),
    .w_regwrite_i (w_regwrite),
    .e_memread_i  (e_memread),
    .m_memread_i  (m_memread),
    .src_o        (src_b),
    .stall_req_o  (stall_b)
  );

  assign data_stall = stall_a | stall_b;
  assign mdu_start  = e_valid & e_multi & MDU_MULTI;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HZ_RUN;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // State and count advance even while the data memory freezes the pipe.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      HZ_RUN: begin
        if (e_redirect) begin
          if (imem_busy) state_d = HZ_FETCH_DRAIN;
        end else if (mdu_start) begin
          state_d = HZ_MDU_WAIT;
          count_d = MDU_START;
        end
      end
      HZ_MDU_WAIT: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else if (!dmem_busy) begin
          state_d = HZ_RUN;
        end
      end
      HZ_FETCH_DRAIN: begin
        if (!imem_busy) state_d = HZ_RUN;
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_comb begin
    en_f     = 1'b1;
    en_d     = 1'b1;
    en_e     = 1'b1;
    en_m     = 1'b1;
    en_w     = 1'b1;
    flush_d  = 1'b0;
    bub_e    = 1'b0;
    bub_m    = 1'b0;
    mdu_done = 1'b0;
    fwd_a    = src_a;
    fwd_b    = src_b;
    unique case (state_q)
      HZ_RUN: begin
        if (e_redirect) begin
          flush_d = 1'b1;
          en_f    = !imem_busy;
        end else if (mdu_start) begin
          {en_f, en_d, en_e} = 3'b000;
          bub_m              = 1'b1;
        end else if (data_stall) begin
          {en_f, en_d} = 2'b00;
          bub_e        = 1'b1;
        end
      end
      HZ_MDU_WAIT: begin
        if (count_q == '0) begin
          mdu_done = 1'b1;
        end else begin
          {en_f, en_d, en_e} = 3'b000;
          bub_m              = 1'b1;
        end
      end
      HZ_FETCH_DRAIN: begin
        en_f    = 1'b0;
        flush_d = 1'b1;
      end
      default: ;
    endcase
    if (dmem_busy) begin
      {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
      {flush_d, bub_e, bub_m}        = 3'b000;
      mdu_done                       = 1'b0;
    end
    if (reset) begin
      {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
      {flush_d, bub_e, bub_m}        = 3'b000;
      mdu_done                       = 1'b0;
      fwd_a                          = RD;
      fwd_b                          = RD;
    end
  end

  assign stall_d      = (!en_f && (stall_q != {CNT_W{1'b1}})) ? stall_q + 1'b1 : stall_q;
  assign stall_cycles = stall_q;
  assign dbg_state_o  = state_q;

endmodule
